// File: rtl/inv_softplus_pkg.sv
// Shared constants, default coefficient table and sign-magnitude arithmetic
// helpers for the inverse-softplus pipeline.
package inv_softplus_pkg;

  localparam int BITSIZE = 16;
  localparam int FRAC    = 11;
  localparam int NSEG    = 8;
  localparam int KW      = $clog2(NSEG);

  // cfg_addr regions: m0..m7, c0..c7, b1..b7; anything above B_LAST is ignored
  localparam logic [4:0] CFG_C_BASE = 5'd8;
  localparam logic [4:0] CFG_B_BASE = 5'd16;
  localparam logic [4:0] CFG_B_LAST = 5'd22;

  typedef struct packed {
    logic [BITSIZE-1:0] val;
    logic               sat;
  } sm_result_t;

  // Slopes, Q4.11 sign-magnitude
  localparam logic [BITSIZE-1:0] M_DEFAULT [NSEG] = '{
    16'h5CC3, 16'h307D, 16'h1A6F, 16'h0F96,
    16'h0A82, 16'h0882, 16'h0809, 16'h0800
  };

  // Intercepts, Q4.11 sign-magnitude (all non-positive)
  localparam logic [BITSIZE-1:0] C_DEFAULT [NSEG] = '{
    16'h9BBA, 16'h9631, 16'h90AD, 16'h8B41,
    16'h862D, 16'h822E, 16'h804B, 16'h0000
  };

  // Breakpoints b1..b7 as unsigned magnitudes
  localparam logic [BITSIZE-2:0] B_DEFAULT [NSEG-1] = '{
    15'h0100, 15'h0200, 15'h0400, 15'h0800,
    15'h1000, 15'h2000, 15'h4000
  };

  // Magnitude product, rounded half-up back to Q4.11 and clamped to full scale
  function automatic sm_result_t sm_mul(input logic [BITSIZE-1:0] a,
                                        input logic [BITSIZE-1:0] b);
    logic [2*BITSIZE-3:0] prod;
    logic [2*BITSIZE-2:0] rnd;
    logic [2*BITSIZE-2-FRAC:0] mag;
    sm_result_t r;
    prod  = (2*BITSIZE-2)'(a[BITSIZE-2:0]) * (2*BITSIZE-2)'(b[BITSIZE-2:0]);
    rnd   = {1'b0, prod} + (2*BITSIZE-1)'(1 << (FRAC-1));
    mag   = (2*BITSIZE-1-FRAC)'(rnd >> FRAC);
    r.sat = 1'b0;
    if (mag > (2*BITSIZE-1-FRAC)'({(BITSIZE-1){1'b1}})) begin
      r.val = {a[BITSIZE-1] ^ b[BITSIZE-1], {(BITSIZE-1){1'b1}}};
      r.sat = 1'b1;
    end else if (mag == '0) begin
      r.val = '0;
    end else begin
      r.val = {a[BITSIZE-1] ^ b[BITSIZE-1], mag[BITSIZE-2:0]};
    end
    return r;
  endfunction

  // Sign-magnitude add; like signs saturate, unlike signs take the larger sign
  function automatic sm_result_t sm_add(input logic [BITSIZE-1:0] a,
                                        input logic [BITSIZE-1:0] b);
    logic [BITSIZE-1:0] sum;
    logic [BITSIZE-2:0] mag;
    logic               sgn;
    sm_result_t r;
    r.sat = 1'b0;
    sum   = '0;
    if (a[BITSIZE-1] == b[BITSIZE-1]) begin
      sum = {1'b0, a[BITSIZE-2:0]} + {1'b0, b[BITSIZE-2:0]};
      sgn = a[BITSIZE-1];
      if (sum[BITSIZE-1]) begin
        mag   = '1;
        r.sat = 1'b1;
      end else begin
        mag = sum[BITSIZE-2:0];
      end
    end else if (a[BITSIZE-2:0] >= b[BITSIZE-2:0]) begin
      mag = a[BITSIZE-2:0] - b[BITSIZE-2:0];
      sgn = a[BITSIZE-1];
    end else begin
      mag = b[BITSIZE-2:0] - a[BITSIZE-2:0];
      sgn = b[BITSIZE-1];
    end
    r.val = (mag == '0) ? '0 : {sgn, mag};
    return r;
  endfunction

endpackage

// File: rtl/inv_softplus_8slice_piped_seg_select.sv
// Priority comparator: picks the first segment whose upper breakpoint is above y.
module inv_softplus_seg_select
  import inv_softplus_pkg::*;
(
  input  logic [BITSIZE-2:0] y,
  input  logic [BITSIZE-2:0] bp [NSEG-1],
  output logic [KW-1:0]      k
);

  // Scan from the top breakpoint down so the smallest matching segment wins
  always_comb begin
    k = KW'(NSEG-1);
    for (int i = NSEG-2; i >= 0; i--) begin
      if (y < bp[i]) k = KW'(i);
    end
  end

endmodule

// File: rtl/inv_softplus_8slice_piped.sv
// Three-stage piecewise-linear inverse softplus with a writable coefficient
// table and a single global advance enable for valid/ready flow control.
module inv_softplus_8slice_piped
  import inv_softplus_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BITSIZE-1:0] data_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BITSIZE-1:0] data_out,
  output logic               out_sat,
  input  logic               cfg_we,
  input  logic [4:0]         cfg_addr,
  input  logic [BITSIZE-1:0] cfg_wdata
);

  logic [BITSIZE-1:0] m_tab [NSEG];
  logic [BITSIZE-1:0] c_tab [NSEG];
  logic [BITSIZE-2:0] b_tab [NSEG-1];

  logic               en;
  logic [KW-1:0]      seg;
  logic               in_bad;

  logic               s1_valid;
  logic [BITSIZE-1:0] s1_m;
  logic [BITSIZE-1:0] s1_c;
  logic [BITSIZE-1:0] s1_y;
  logic               s1_bad;

  logic               s2_valid;
  logic [BITSIZE-1:0] s2_prod;
  logic               s2_psat;
  logic [BITSIZE-1:0] s2_c;
  logic               s2_bad;

  sm_result_t         mul_res;
  sm_result_t         add_res;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Negative inputs and both zeros have no inverse-softplus value
  assign in_bad = data_in[BITSIZE-1] || (data_in[BITSIZE-2:0] == '0);

  inv_softplus_seg_select u_seg_select (
    .y  (data_in[BITSIZE-2:0]),
    .bp (b_tab),
    .k  (seg)
  );

  assign mul_res = sm_mul(s1_m, s1_y);
  assign add_res = sm_add(s2_prod, s2_c);

  // Coefficient table: defaults on reset, otherwise one word per cfg_we strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NSEG; i++) begin
        m_tab[i] <= M_DEFAULT[i];
        c_tab[i] <= C_DEFAULT[i];
      end
      for (int i = 0; i < NSEG-1; i++) begin
        b_tab[i] <= B_DEFAULT[i];
      end
    end else if (cfg_we) begin
      if (cfg_addr < CFG_C_BASE) begin
        m_tab[cfg_addr[2:0]] <= cfg_wdata;
      end else if (cfg_addr < CFG_B_BASE) begin
        c_tab[cfg_addr[2:0]] <= cfg_wdata;
      end else if (cfg_addr <= CFG_B_LAST) begin
        b_tab[cfg_addr[2:0]] <= cfg_wdata[BITSIZE-2:0];
      end
    end
  end

  // S1: latch the selected coefficients, the operand and the domain flag
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_m     <= '0;
      s1_c     <= '0;
      s1_y     <= '0;
      s1_bad   <= 1'b0;
    end else if (en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_m   <= m_tab[seg];
        s1_c   <= c_tab[seg];
        s1_y   <= data_in;
        s1_bad <= in_bad;
      end
    end
  end

  // S2: rounded and clamped slope product, intercept carried alongside
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_prod  <= '0;
      s2_psat  <= 1'b0;
      s2_c     <= '0;
      s2_bad   <= 1'b0;
    end else if (en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_prod <= mul_res.val;
        s2_psat <= mul_res.sat;
        s2_c    <= s1_c;
        s2_bad  <= s1_bad;
      end
    end
  end

  // S3: output register; out-of-domain samples are forced to the most negative code
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      out_sat   <= 1'b0;
    end else if (en) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        data_out <= s2_bad ? '1 : add_res.val;
        out_sat  <= s2_bad || s2_psat || add_res.sat;
      end
    end
  end

endmodule

// File: tb/tb_inv_softplus_8slice_piped.sv
// Directed self-checking bench for the inverse-softplus pipeline.
module tb_inv_softplus_8slice_piped;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] data_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] data_out;
  logic        out_sat;
  logic        cfg_we;
  logic [4:0]  cfg_addr;
  logic [15:0] cfg_wdata;

  int num_checks = 0;
  int num_fails  = 0;

  // Hand-computed expectations for the default table
  logic [15:0] stream_y [16] = '{
    16'h0800, 16'h4000, 16'h7FFF, 16'h0000, 16'h2000, 16'h1000, 16'h0080, 16'h0100,
    16'h0200, 16'h0400, 16'h0001, 16'h0010, 16'h8000, 16'h5000, 16'h8800, 16'h6000
  };
  logic [15:0] stream_exp [16] = '{
    16'h0455, 16'h4000, 16'h7FFF, 16'hFFFF, 16'h1FD9, 16'h0ED6, 16'h95EE, 16'h9021,
    16'h8A11, 16'h8376, 16'h9BAE, 16'h9B00, 16'hFFFF, 16'h5000, 16'hFFFF, 16'h6000
  };
  logic stream_sat [16] = '{
    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0
  };

  inv_softplus_8slice_piped dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .out_sat   (out_sat),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    num_checks++;
    if (got !== want) begin
      num_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic cfgWrite(input logic [4:0] addr, input logic [15:0] wdata);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = wdata;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // One isolated sample: checks latency, value and saturation flag
  task automatic applyStimulus(input logic [15:0] y, input logic [15:0] want,
                               input logic want_sat, input string tag);
    int wait_cycles;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    data_in   = y;
    @(negedge clk);
    in_valid    = 1'b0;
    wait_cycles = 1;
    while (!out_valid && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    checkOutput({tag, "_latency"}, wait_cycles, 3);
    checkOutput({tag, "_data"}, data_out, want);
    checkOutput({tag, "_sat"}, out_sat, want_sat);
  endtask

  // Back-to-back stream with out_ready following 1,0,0,1,0,0,...
  task automatic runStream();
    int          sent;
    int          recv;
    int          extra;
    logic        held;
    logic [15:0] held_data;
    logic        held_sat;
    sent  = 0;
    recv  = 0;
    extra = 0;
    held  = 1'b0;
    held_data = '0;
    held_sat  = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      out_ready = (cyc % 3 == 0);
      in_valid  = (sent < 16);
      data_in   = (sent < 16) ? stream_y[sent] : 16'h0000;
      #1;
      if (held) begin
        checkOutput("stall_valid", out_valid, 1);
        checkOutput("stall_data", data_out, held_data);
        checkOutput("stall_sat", out_sat, held_sat);
        held = 1'b0;
      end
      if (out_valid) begin
        if (out_ready) begin
          if (recv < 16) begin
            checkOutput($sformatf("stream%0d_data", recv), data_out, stream_exp[recv]);
            checkOutput($sformatf("stream%0d_sat", recv), out_sat, stream_sat[recv]);
          end
          recv++;
        end else begin
          held      = 1'b1;
          held_data = data_out;
          held_sat  = out_sat;
        end
      end
      if (in_valid && in_ready) sent++;
      if (recv >= 16) break;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput("stream_count", recv, 16);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    checkOutput("stream_extra", extra, 0);
  endtask

  // Reset with three samples in flight must drop all of them
  task automatic midStreamReset();
    int seen;
    seen = 0;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      data_in  = 16'h5000 + 16'(i * 16'h0800);
      @(negedge clk);
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("flush_valid", out_valid, 0);
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checkOutput("flush_quiet", seen, 0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    data_in   = '0;
    out_ready = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;

    $display("[TB] reset state");
    doReset();
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_data_out", data_out, 16'h0000);
    checkOutput("rst_out_sat", out_sat, 0);
    checkOutput("rst_in_ready", in_ready, 1);

    $display("[TB] single samples");
    applyStimulus(16'h0800, 16'h0455, 1'b0, "y_1p0");
    applyStimulus(16'h4000, 16'h4000, 1'b0, "y_8p0");
    applyStimulus(16'h7FFF, 16'h7FFF, 1'b0, "y_max");
    applyStimulus(16'h0000, 16'hFFFF, 1'b1, "y_pzero");
    applyStimulus(16'h8000, 16'hFFFF, 1'b1, "y_nzero");
    applyStimulus(16'h8800, 16'hFFFF, 1'b1, "y_neg1");

    $display("[TB] stream with back-pressure");
    runStream();

    $display("[TB] coefficient writes");
    cfgWrite(5'd23, 16'hFFFF);
    applyStimulus(16'h4000, 16'h4000, 1'b0, "ignored_addr");
    cfgWrite(5'd7, 16'h1000);
    applyStimulus(16'h4000, 16'h7FFF, 1'b1, "m7_double");
    doReset();
    applyStimulus(16'h4000, 16'h4000, 1'b0, "m7_restored");

    $display("[TB] reset mid-stream");
    midStreamReset();

    $display("== %0d vectors applied, %0d miscompares ==", num_checks, num_fails);
    $finish;
  end

endmodule
